// File: rtl/rst_seq_sync.sv
// Multi-channel reset sequencer: drives per-domain reset requests, synchronises them out and
// their acks back, holds, then releases together or in channel order. Option: RST_SEQ_TIMEOUT_EN.
module rst_seq_sync #(
   parameter int NUM_CH         = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int SEQ_RELEASE    = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] dst_clk,
   input  logic              sw_rst_req,
   output logic [NUM_CH-1:0] chan_rst,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      ST_ASSERT   = 3'd0,
      ST_WAIT_ACK = 3'd1,
      ST_HOLD     = 3'd2,
      ST_RELEASE  = 3'd3,
      ST_WAIT_REL = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam int              HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam int              KW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [KW-1:0]   K_LAST    = KW'(NUM_CH - 1);

   if (NUM_CH < 1 || NUM_CH > 8 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("rst_seq_sync: illegal parameter combination");
   end

   state_t              r_state;
   logic [NUM_CH-1:0]   r_req;
   logic [HW-1:0]       r_hold;
   logic [KW-1:0]       r_k;
   logic                r_busy;
   logic                r_done;
   logic [NUM_CH-1:0]   r_ack_pipe [SYNC_STAGES];
   logic [NUM_CH-1:0]   w_ack;
   logic                w_rel_met;
   logic                w_to_hit;

   // Destination flops are unreset; a held request is what resets them.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_fwd;
      always_ff @(posedge dst_clk[i]) begin
         r_fwd <= {r_fwd[SYNC_STAGES-2:0], r_req[i]};
      end
      assign chan_rst[i] = r_fwd[SYNC_STAGES-1];
   end

   always_ff @(posedge sys_clk) begin
      r_ack_pipe[0] <= chan_rst;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         r_ack_pipe[s] <= r_ack_pipe[s-1];
      end
   end

   assign w_ack     = r_ack_pipe[SYNC_STAGES-1];
   assign w_rel_met = (SEQ_RELEASE != 0) ? ~w_ack[r_k] : ~|w_ack;

`ifdef RST_SEQ_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_to_err;
   logic          w_waiting;

   // Leaving a wait state always passes through a non-wait state, which clears the count.
   assign w_waiting = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_REL);
   assign w_to_hit  = w_waiting && (r_to_cnt == TO_LAST);

   always_ff @(posedge sys_clk) begin
      if (rst || !w_waiting) begin
         r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LAST) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (rst) begin
         r_to_err <= 1'b0;
      end else if (w_to_hit) begin
         r_to_err <= 1'b1;
      end
   end

   assign timeout_err = r_to_err;
`else
   assign w_to_hit    = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Reset keeps every request asserted so a mid-sequence reset never lets chan_rst drop.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= ST_ASSERT;
         r_req   <= '1;
         r_hold  <= '0;
         r_k     <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_ASSERT: begin
               r_req   <= '1;
               r_hold  <= '0;
               r_k     <= '0;
               r_state <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if ((&w_ack) || w_to_hit) r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (r_hold >= HOLD_LAST) begin
                  r_hold  <= '0;
                  r_state <= ST_RELEASE;
               end else begin
                  r_hold <= r_hold + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (SEQ_RELEASE != 0) r_req[r_k] <= 1'b0;
               else                  r_req      <= '0;
               r_state <= ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
               if (w_rel_met || w_to_hit) begin
                  if ((SEQ_RELEASE != 0) && (r_k != K_LAST)) begin
                     r_k     <= r_k + 1'b1;
                     r_state <= ST_RELEASE;
                  end else begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (sw_rst_req) begin
                  r_state <= ST_ASSERT;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_ASSERT;
               r_busy  <= 1'b1;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule
